// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo tone generator: FSM state codes, the
// note frequency table and the half-period helper used to build the ROM.
package piezo_pkg;

  // FSM state encoding, also visible on the state_dbg port
  localparam logic [1:0] ST_SILENT = 2'd0;
  localparam logic [1:0] ST_GAP    = 2'd1;
  localparam logic [1:0] ST_TONE   = 2'd2;

  // Note frequency in milli-Hz for codes 1..8 (C4 D4 E4 F4 G4 A4 B4 C5).
  // Centi-Hz is too coarse to land C4 on 95556 at 50 MHz, so one extra
  // decimal digit is carried. Rest codes return 0.
  function automatic longint note_freq_mhz(input int code);
    case (code)
      1:       return 64'd261626;
      2:       return 64'd293665;
      3:       return 64'd329628;
      4:       return 64'd349228;
      5:       return 64'd391995;
      6:       return 64'd440000;
      7:       return 64'd493880;
      8:       return 64'd523251;
      default: return 64'd0;
    endcase
  endfunction

  // Rounded half-period in clock cycles: round(clk_hz / (2 * f)).
  function automatic int half_period(input longint clk_hz, input int code);
    longint f;
    f = note_freq_mhz(code);
    if (f == 0) return 0;
    return int'((clk_hz * 1000 + f) / (2 * f));
  endfunction

endpackage

// File: rtl/piezo_hp_rom.sv
// Combinational note-code to half-period lookup, built at elaboration time.
module piezo_hp_rom
  import piezo_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int HP_W   = 17
) (
  input  logic [3:0]      code,
  output logic [HP_W-1:0] hp
);

  // Every half-period must fit in the counter; C4 is the largest
  for (genvar i = 1; i <= 8; i++) begin : g_chk
    if (longint'(half_period(CLK_HZ, i)) >= (longint'(1) << HP_W)) begin : g_bad
      $error("piezo_hp_rom: HP_W too small for note code %0d", i);
    end
  end

  // Table lookup; rest codes give 0 and are never loaded by the FSM
  always_comb begin
    hp = '0;
    case (code)
      4'd1: hp = HP_W'(half_period(CLK_HZ, 1));
      4'd2: hp = HP_W'(half_period(CLK_HZ, 2));
      4'd3: hp = HP_W'(half_period(CLK_HZ, 3));
      4'd4: hp = HP_W'(half_period(CLK_HZ, 4));
      4'd5: hp = HP_W'(half_period(CLK_HZ, 5));
      4'd6: hp = HP_W'(half_period(CLK_HZ, 6));
      4'd7: hp = HP_W'(half_period(CLK_HZ, 7));
      4'd8: hp = HP_W'(half_period(CLK_HZ, 8));
      default: hp = '0;
    endcase
  end

endmodule

// File: rtl/piezo_tone_gen.sv
// Piezo tone generator: note code in, glitch-free square wave out, with a
// silent gap between different notes so consecutive notes articulate.
// All outputs are registered. There is no handshake: note_code and enable
// are level inputs sampled on every rising clk edge.
module piezo_tone_gen
  import piezo_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int GAP_CYCLES = 2_500_000,
  parameter int HP_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_code,
  output logic       piezo_out,
  output logic       note_active,
  output logic [3:0] cur_note,
  output logic       note_start,
  output logic [1:0] state_dbg
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]      state;
  logic [HP_W-1:0] hp_cnt;
  logic [HP_W-1:0] hp_reg;
  logic [HP_W-1:0] rom_hp;
  logic [GW-1:0]   gap_cnt;
  logic            code_ok;
  logic            hp_done;
  logic            go_tone;
  logic            go_gap;
  logic            go_silent;

  piezo_hp_rom #(.CLK_HZ(CLK_HZ), .HP_W(HP_W)) u_rom (
    .code (note_code),
    .hp   (rom_hp)
  );

  assign code_ok   = enable && (note_code >= 4'd1) && (note_code <= 4'd8);
  assign hp_done   = (hp_cnt == hp_reg - HP_W'(1));
  assign state_dbg = state;

  // Transition decisions; priority is disable/rest, then note change, then toggle.
  // Leaving GAP always uses the code present on the last gap cycle: any
  // invalid code would already have sent us to SILENT, so that code is the
  // most recent valid one and no separate pending register is needed.
  always_comb begin
    go_tone   = 1'b0;
    go_gap    = 1'b0;
    go_silent = 1'b0;
    case (state)
      ST_SILENT: go_tone = code_ok;
      ST_TONE: begin
        if (!code_ok) begin
          go_silent = 1'b1;
        end else if (note_code != cur_note) begin
          if (GAP_CYCLES > 0) go_gap  = 1'b1;
          else                go_tone = 1'b1;
        end
      end
      ST_GAP: begin
        if (!code_ok)                 go_silent = 1'b1;
        else if (gap_cnt == GAP_LAST) go_tone   = 1'b1;
      end
      default: go_silent = 1'b1;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_SILENT;
      hp_cnt      <= '0;
      hp_reg      <= '0;
      gap_cnt     <= '0;
      piezo_out   <= 1'b0;
      note_active <= 1'b0;
      cur_note    <= 4'd0;
      note_start  <= 1'b0;
    end else if (go_tone) begin
      state       <= ST_TONE;
      hp_reg      <= rom_hp;
      hp_cnt      <= '0;
      gap_cnt     <= '0;
      piezo_out   <= 1'b1;
      note_active <= 1'b1;
      cur_note    <= note_code;
      note_start  <= 1'b1;
    end else if (go_silent || go_gap) begin
      state       <= go_gap ? ST_GAP : ST_SILENT;
      hp_cnt      <= '0;
      gap_cnt     <= '0;
      piezo_out   <= 1'b0;
      note_active <= 1'b0;
      cur_note    <= 4'd0;
      note_start  <= 1'b0;
    end else begin
      note_start <= 1'b0;
      if (state == ST_TONE) begin
        if (hp_done) begin
          piezo_out <= ~piezo_out;
          hp_cnt    <= '0;
        end else begin
          hp_cnt <= hp_cnt + HP_W'(1);
        end
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Bench for piezo_tone_gen: two instances (gap of 100 clk and no gap) share
// the stimulus; a time-based reference model predicts every output cycle.
module tb_piezo_tone_gen;

  localparam int TB_CLK = 500_000;
  localparam int TB_GAP = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] note_code;
  always #5 clk = ~clk;

  logic       p_a, a_a, s_a, p_b, a_b, s_b;
  logic [3:0] c_a, c_b;
  logic [1:0] st_a, st_b;

  piezo_tone_gen #(.CLK_HZ(TB_CLK), .GAP_CYCLES(TB_GAP), .HP_W(17)) dut_gap (
    .clk(clk), .reset(reset), .enable(enable), .note_code(note_code),
    .piezo_out(p_a), .note_active(a_a), .cur_note(c_a), .note_start(s_a),
    .state_dbg(st_a)
  );

  piezo_tone_gen #(.CLK_HZ(TB_CLK), .GAP_CYCLES(0), .HP_W(17)) dut_nogap (
    .clk(clk), .reset(reset), .enable(enable), .note_code(note_code),
    .piezo_out(p_b), .note_active(a_b), .cur_note(c_b), .note_start(s_b),
    .state_dbg(st_b)
  );

  // Half-period table at the default 50 MHz clock
  logic [3:0]  rom_code;
  logic [16:0] rom_hp;
  piezo_hp_rom #(.CLK_HZ(50_000_000), .HP_W(17)) u_rom_def (
    .code(rom_code), .hp(rom_hp)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int mode;   // 0 silent, 1 gap, 2 tone
    int note;
    int t0;     // edge index where the current tone started
    int gs;     // edge index where the current gap started
  } mdl_t;

  int   hp_tab [1:8];
  int   cyc;
  mdl_t ma, mb;
  int   n_vec;
  int   n_miss;
  logic [6:0] exp_q[$];

  function automatic mdl_t mdl_step(mdl_t m, bit rst_n, bit en, int code, int now, int gap);
    bit v;
    v = en && code >= 1 && code <= 8;
    if (!rst_n) begin
      m.mode = 0;
      return m;
    end
    case (m.mode)
      0: if (v) begin m.mode = 2; m.note = code; m.t0 = now; end
      2: begin
        if (!v) m.mode = 0;
        else if (code != m.note) begin
          if (gap > 0) begin m.mode = 1; m.gs = now; end
          else begin m.note = code; m.t0 = now; end
        end
      end
      default: begin
        if (!v) m.mode = 0;
        else if (now - m.gs == gap) begin m.mode = 2; m.note = code; m.t0 = now; end
      end
    endcase
    return m;
  endfunction

  // Expected {piezo_out, note_active, cur_note, note_start}
  function automatic logic [6:0] mdl_out(mdl_t m, int now);
    logic p;
    if (m.mode != 2) return 7'd0;
    p = (((now - m.t0) / hp_tab[m.note]) % 2) == 0;
    return {p, 1'b1, 4'(m.note), (m.t0 == now)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic cmp(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    assert (got[6] === exp[6]) else begin
      n_miss++;
      $error("FAIL %s cyc=%0d piezo_out got %b exp %b", tag, cyc, got[6], exp[6]);
    end
    n_vec++;
    assert (got[5] === exp[5]) else begin
      n_miss++;
      $error("FAIL %s cyc=%0d note_active got %b exp %b", tag, cyc, got[5], exp[5]);
    end
    n_vec++;
    assert (got[4:1] === exp[4:1]) else begin
      n_miss++;
      $error("FAIL %s cyc=%0d cur_note got %0d exp %0d", tag, cyc, got[4:1], exp[4:1]);
    end
    n_vec++;
    assert (got[0] === exp[0]) else begin
      n_miss++;
      $error("FAIL %s cyc=%0d note_start got %b exp %b", tag, cyc, got[0], exp[0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit r, input bit e, input logic [3:0] c, input string tag);
    reset = r; enable = e; note_code = c;
    @(posedge clk);
    cyc++;
    ma = mdl_step(ma, r, e, int'(c), cyc, TB_GAP);
    mb = mdl_step(mb, r, e, int'(c), cyc, 0);
    exp_q.push_back(mdl_out(ma, cyc));
    exp_q.push_back(mdl_out(mb, cyc));
    @(negedge clk);
    cmp({tag, "/gap"},   {p_a, a_a, c_a, s_a}, exp_q.pop_front());
    cmp({tag, "/nogap"}, {p_b, a_b, c_b, s_b}, exp_q.pop_front());
  endtask

  task automatic hold(input bit r, input bit e, input logic [3:0] c, input int n, input string tag);
    repeat (n) tick(r, e, c, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int semi [1:8];
    int hp_spec [1:8];
    semi    = '{-9, -7, -5, -4, -2, 0, 2, 3};
    hp_spec = '{95556, 85131, 75843, 71586, 63776, 56818, 50620, 47778};
    for (int i = 1; i <= 8; i++) begin
      real f;
      f = 440.0 * (2.0 ** (real'(semi[i]) / 12.0));
      hp_tab[i] = $rtoi(real'(TB_CLK) / (2.0 * f) + 0.5);
    end
    n_vec = 0; n_miss = 0; cyc = 0;
    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    reset = 1'b0; enable = 1'b0; note_code = 4'd0; rom_code = 4'd0;

    // Default-clock half-period table
    for (int i = 1; i <= 8; i++) begin
      rom_code = 4'(i);
      #1;
      n_vec++;
      assert (int'(rom_hp) === hp_spec[i]) else begin
        n_miss++;
        $error("FAIL rom_default code=%0d hp got %0d exp %0d", i, rom_hp, hp_spec[i]);
      end
    end

    // Reset held with a note present, then release into A4
    hold(0, 1, 4'd6, 3, "t1_reset");
    hold(1, 1, 4'd6, 3 * hp_tab[6] + 7, "t1_a4");
    hold(1, 1, 4'd0, 50, "rest");

    // C4 held for four full periods
    hold(1, 1, 4'd1, 8 * hp_tab[1] + 3, "t2_c4");

    // Note change mid half-period goes through the gap
    hold(1, 1, 4'd3, 300, "t3_e4");
    hold(1, 1, 4'd5, TB_GAP + 3 * hp_tab[5], "t3_g4");

    // Code changes and aborts during the gap
    hold(1, 1, 4'd2, 200, "t4_d4");
    hold(1, 1, 4'd5, 40, "t4_gap5");
    hold(1, 1, 4'd8, TB_GAP + 2 * hp_tab[8], "t4_gap8");
    hold(1, 1, 4'd3, 30, "t4_chg");
    hold(1, 1, 4'd0, 20, "t4_rest_gap");
    hold(1, 1, 4'd4, 300, "t4_f4");
    hold(1, 1, 4'd6, 30, "t4_chg2");
    hold(1, 0, 4'd6, 20, "t4_dis_gap");

    // One-cycle enable drop mid-tone
    hold(1, 1, 4'd7, 300, "t5_b4");
    hold(1, 0, 4'd7, 1, "t5_drop");
    hold(1, 1, 4'd7, 2 * hp_tab[7] + 5, "t5_reen");

    // Retune 2 -> 7, then every out-of-range code
    hold(1, 1, 4'd2, 400, "t6_d4");
    hold(1, 1, 4'd7, TB_GAP + 2 * hp_tab[7] + 5, "t6_b4");
    for (int c = 9; c <= 15; c++) begin
      hold(1, 1, 4'd4, 20, "t6_pre");
      hold(1, 1, 4'(c), 5, "t6_rest");
    end

    // Reset mid-tone and mid-gap
    hold(1, 1, 4'd4, 200, "rst_tone_pre");
    hold(0, 1, 4'd4, 2, "rst_tone");
    hold(1, 1, 4'd4, 100, "rst_tone_post");
    hold(1, 1, 4'd1, 50, "rst_gap_pre");
    hold(0, 1, 4'd1, 1, "rst_gap");
    hold(1, 1, 4'd1, 100, "rst_gap_post");

    // Randomized segments
    for (int k = 0; k < 60; k++) begin
      logic [3:0] c;
      bit e, r;
      int len;
      if ($urandom_range(0, 9) < 7) c = 4'($urandom_range(1, 8));
      else                          c = 4'($urandom_range(0, 15));
      e   = ($urandom_range(0, 9) != 0);
      r   = ($urandom_range(0, 29) != 0);
      len = $urandom_range(1, 400);
      hold(r, e, c, len, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
